mcpu_prog_loader: RTL
=====================

Name: mcpu_prog_loader

Overview:
- Hardware program loader for MCPU: receives a framed byte stream and writes 16-bit instruction words into the MCPU RAM write port, starting at a base address.
- Holds the CPU in reset until a complete frame with a valid checksum has been written, then releases it.
- Performs in silicon the RAM image load that simulation does with direct memory writes.

Parameters:
- WORD_SIZE, 16, instruction width in bits; must be 16 (two bytes per word).
- ADDR_SIZE, 8, RAM address width (256 words).
- SYNC_BYTE, 8'hA5, frame start marker.
- BASE_ADDR, 0, RAM address of the first loaded word.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- in_data  input  8  stream byte.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  loader accepts a byte; transfer occurs when in_valid and in_ready are both high on a rising edge.
- restart  input  1  from DONE or ERR, return to IDLE and reassert cpu_reset.
- mem_we  output  1  RAM write strobe, one cycle per word.
- mem_addr  output  ADDR_SIZE  RAM write address.
- mem_wdata  output  WORD_SIZE  RAM write data.
- cpu_reset  output  1  active-high reset to MCPU.
- done  output  1  load completed with a good checksum (level).
- error  output  1  checksum mismatch (level).

Behaviour:
- Reset (reset=0, asynchronous) forces:
  - state=IDLE, in_ready=1, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0.
  - cpu_reset=1, done=0, error=0, counters=0, checksum=0.
- Frame format: SYNC_BYTE, COUNT, then COUNT words sent high byte first, then CHK.
  - COUNT=0 means 256 words.
  - CHK is the XOR of all word bytes; SYNC and COUNT are excluded.
- States and transitions (one accepted byte per transition):
  - IDLE: accept a byte. Byte==SYNC_BYTE goes to CNT; any other byte is discarded and the loader stays in IDLE. Checksum is cleared on leaving IDLE.
  - CNT: latch remaining=COUNT (9-bit; 0 maps to 256), set addr=BASE_ADDR, go to HI.
  - HI: latch hi byte, XOR it into checksum, go to LO.
  - LO: XOR lo byte into checksum. On the next cycle drive mem_we=1, mem_wdata={hi,lo}, mem_addr=addr, then addr+=1. Decrement remaining; go to CHK if it reaches 0, else to HI.
  - CHK: if byte==checksum go to DONE, else go to ERR.
  - DONE: done=1, cpu_reset=0, in_ready=0.
  - ERR: error=1, cpu_reset=1, in_ready=0.
  - restart=1 in DONE or ERR returns to IDLE the next cycle: done, error and checksum cleared, cpu_reset=1, in_ready=1. restart is ignored in all other states.
- Write latency: mem_we is asserted exactly one cycle after the LO byte is accepted. in_ready stays 1 during the write, so a back-to-back HI byte may be accepted in the same cycle as the write.
- Address wrap: mem_addr increments modulo 2^ADDR_SIZE. With BASE_ADDR!=0 and 256 words, the load wraps to address 0.
- in_valid=0 stalls any state; no timeout.
- Writes already issued in a frame that ends in ERR are not rolled back. The CPU stays in reset until a good frame is loaded.
- Asynchronous reset mid-frame aborts immediately to reset values; a partially loaded RAM stays as written.
- cpu_reset, done, error and in_ready are registered outputs (no combinational path from in_data).

Test Plan:
- Load SYNC, 02, 84,44, 8A,08, CHK=0x84^0x44^0x8A^0x08=0x42 -> mem_we pulses at addr 0 (0x8444) and addr 1 (0x8A08); done=1, cpu_reset=0 one cycle after CHK.
- Same frame with CHK=0x00 -> both words written; error=1, cpu_reset stays 1. Then restart=1 plus a good frame -> done=1.
- Bytes 00, FF, then SYNC, 01, 12,34, CHK=0x26 -> garbage ignored; addr 0 = 0x1234; done=1.
- COUNT=00 with 256 words, BASE_ADDR=8'hF0 -> 256 writes, addresses F0..FF then 00..EF; done=1 after CHK.
- in_valid toggled every other cycle during frame -> identical writes and final state as the back-to-back case; mem_we never asserted twice for one word.
- reset pulsed low after the HI byte of word 1 -> immediate return to IDLE with cpu_reset=1 and no pending write. A subsequent full frame loads correctly.

Source files
------------

// File: rtl/mcpu_prog_loader_if.sv
// rtl/mcpu_prog_loader_if.sv - byte stream and RAM write port bundle for the program loader
interface mcpu_prog_loader_if #(
    parameter int WORD_SIZE = 16,
    parameter int ADDR_SIZE = 8
);
    logic [7:0]           in_data;
    logic                 in_valid;
    logic                 in_ready;
    logic                 mem_we;
    logic [ADDR_SIZE-1:0] mem_addr;
    logic [WORD_SIZE-1:0] mem_wdata;

    modport master (
        input  in_data,
        input  in_valid,
        output in_ready,
        output mem_we,
        output mem_addr,
        output mem_wdata
    );

    modport slave (
        output in_data,
        output in_valid,
        input  in_ready,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata
    );
endinterface

// File: rtl/mcpu_prog_loader.sv
// rtl/mcpu_prog_loader.sv - framed byte-stream loader that fills MCPU RAM and releases cpu_reset
module mcpu_prog_loader #(
    parameter int                  WORD_SIZE = 16,
    parameter int                  ADDR_SIZE = 8,
    parameter logic [7:0]          SYNC_BYTE = 8'hA5,
    parameter logic [ADDR_SIZE-1:0] BASE_ADDR = '0
) (
    input  logic                clk,
    input  logic                reset,
    mcpu_prog_loader_if.master  bus,
    input  logic                restart,
    output logic                cpu_reset,
    output logic                done,
    output logic                error
);
    typedef enum logic [2:0] {
        S_IDLE, S_CNT, S_HI, S_LO, S_CHK, S_DONE, S_ERR
    } state_t;

    localparam logic [ADDR_SIZE-1:0] ADDR_ONE = {{(ADDR_SIZE-1){1'b0}}, 1'b1};

    state_t               state;
    logic [8:0]           remaining;
    logic [ADDR_SIZE-1:0] addr;
    logic [7:0]           hi_byte;
    logic [7:0]           checksum;
    logic                 accept;

    assign accept = bus.in_valid && bus.in_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= S_IDLE;
            bus.in_ready  <= 1'b1;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= BASE_ADDR;
            bus.mem_wdata <= '0;
            cpu_reset     <= 1'b1;
            done          <= 1'b0;
            error         <= 1'b0;
            remaining     <= '0;
            addr          <= BASE_ADDR;
            hi_byte       <= '0;
            checksum      <= '0;
        end else begin
            bus.mem_we <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept && bus.in_data == SYNC_BYTE) begin
                        checksum <= '0;
                        state    <= S_CNT;
                    end
                end
                S_CNT: begin
                    if (accept) begin
                        // a zero count encodes a full 256-word image
                        remaining <= (bus.in_data == 8'd0) ? 9'd256 : {1'b0, bus.in_data};
                        addr      <= BASE_ADDR;
                        state     <= S_HI;
                    end
                end
                S_HI: begin
                    if (accept) begin
                        hi_byte  <= bus.in_data;
                        checksum <= checksum ^ bus.in_data;
                        state    <= S_LO;
                    end
                end
                S_LO: begin
                    if (accept) begin
                        checksum      <= checksum ^ bus.in_data;
                        bus.mem_we    <= 1'b1;
                        bus.mem_addr  <= addr;
                        bus.mem_wdata <= {hi_byte, bus.in_data};
                        addr          <= addr + ADDR_ONE;
                        remaining     <= remaining - 9'd1;
                        state         <= (remaining == 9'd1) ? S_CHK : S_HI;
                    end
                end
                S_CHK: begin
                    if (accept) begin
                        bus.in_ready <= 1'b0;
                        if (bus.in_data == checksum) begin
                            done      <= 1'b1;
                            cpu_reset <= 1'b0;
                            state     <= S_DONE;
                        end else begin
                            error     <= 1'b1;
                            cpu_reset <= 1'b1;
                            state     <= S_ERR;
                        end
                    end
                end
                S_DONE, S_ERR: begin
                    if (restart) begin
                        done         <= 1'b0;
                        error        <= 1'b0;
                        checksum     <= '0;
                        cpu_reset    <= 1'b1;
                        bus.in_ready <= 1'b1;
                        state        <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
